// File: rtl/p_i_cache_nway.sv
// rtl/p_i_cache_nway.sv - two-stage pipelined N-way set-associative read-only instruction cache
module p_i_cache_nway #(
   parameter int S_OFFSET = 5,
   parameter int S_INDEX  = 3,
   parameter int NUM_WAYS = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       mem_read,
   input  logic [31:0]                mem_address,
   input  logic                       flush,
   output logic                       mem_resp,
   output logic [31:0]                mem_rdata,
   output logic                       pmem_read,
   output logic [31:0]                pmem_address,
   input  logic [8*(2**S_OFFSET)-1:0] pmem_rdata,
   input  logic                       pmem_resp
);

   localparam int S_LINE   = 8 * (2 ** S_OFFSET);
   localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
   localparam int NUM_SETS = 2 ** S_INDEX;
   localparam int W_WAY    = $clog2(NUM_WAYS);
   localparam int W_PLRU   = NUM_WAYS - 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_FETCH = 1'b1;

   // Flop-based arrays
   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [S_TAG-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
   logic [S_LINE-1:0]   data_q  [NUM_SETS][NUM_WAYS];
   logic [W_PLRU-1:0]   plru_q  [NUM_SETS];

   // Stage-2 register and control state
   logic                s2_valid_q, s2_hit_q;
   logic [31:0]         s2_addr_q;
   logic [NUM_WAYS-1:0] s2_way_q;
   logic [S_LINE-1:0]   s2_line_q;
   logic [0:0]          state_q, state_d;
   logic                flush_pend_q, pmem_read_q;
   logic [31:0]         pmem_addr_q;

   logic [S_INDEX-1:0]  s1_idx, s2_idx;
   logic [S_TAG-1:0]    s1_tag;
   logic [NUM_WAYS-1:0] s1_way;
   logic [S_LINE-1:0]   s1_line;
   logic                s2_miss, s1_accept, fill;
   logic [W_WAY-1:0]    victim, hit_way;
   logic [S_OFFSET+2:0] word_shift;

   // Walk the tree from the root; a 0 node bit selects the lower half.
   function automatic logic [W_WAY-1:0] plru_victim(input logic [W_PLRU-1:0] bits);
      logic [W_PLRU-1:0] t;
      int node;
      node = 1;
      for (int l = 0; l < W_WAY; l++) begin
         t    = bits >> (node - 1);
         node = 2 * node + int'(t[0]);
      end
      return W_WAY'(node - NUM_WAYS);
   endfunction

   // Make every node on the accessed way's path point at the other half.
   function automatic logic [W_PLRU-1:0] plru_touch(input logic [W_PLRU-1:0] bits,
                                                    input logic [W_WAY-1:0]  way);
      logic [W_PLRU-1:0] b;
      logic [W_WAY-1:0]  w;
      int node;
      b    = bits;
      w    = way;
      node = 1;
      for (int l = 0; l < W_WAY; l++) begin
         if (w[W_WAY-1]) b = b & ~(W_PLRU'(1) << (node - 1));
         else            b = b | (W_PLRU'(1) << (node - 1));
         node = 2 * node + int'(w[W_WAY-1]);
         w    = w << 1;
      end
      return b;
   endfunction

   // Stage-1 lookup: tag compare across all ways of the indexed set
   always_comb begin
      s1_idx  = mem_address[S_OFFSET +: S_INDEX];
      s1_tag  = mem_address[31 -: S_TAG];
      s1_way  = '0;
      s1_line = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[s1_idx][w] && (tag_q[s1_idx][w] == s1_tag)) begin
            s1_way[w] = 1'b1;
            s1_line   = s1_line | data_q[s1_idx][w];
         end
      end
   end

   // Stage-2 miss detection, stall/accept, refill victim and next FSM state
   always_comb begin
      s2_idx    = s2_addr_q[S_OFFSET +: S_INDEX];
      s2_miss   = (state_q == ST_IDLE) && s2_valid_q && !s2_hit_q;
      s1_accept = mem_read && !flush && !s2_miss && (state_q == ST_IDLE);
      fill      = (state_q == ST_FETCH) && pmem_resp;
      victim    = plru_victim(plru_q[s2_idx]);
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_q[s2_idx][w]) victim = W_WAY'(w);
      end
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (s2_way_q[w]) hit_way = W_WAY'(w);
      end
      state_d = state_q;
      if (s2_miss)   state_d = ST_FETCH;
      else if (fill) state_d = ST_IDLE;
      word_shift = {s2_addr_q[S_OFFSET-1:0] & ~S_OFFSET'(3), 3'b000};
   end

   assign mem_resp     = s2_valid_q && s2_hit_q;
   assign mem_rdata    = 32'(s2_line_q >> word_shift);
   assign pmem_read    = pmem_read_q;
   assign pmem_address = pmem_addr_q;

   // Pipeline, refill FSM and array updates
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         flush_pend_q <= 1'b0;
         pmem_read_q  <= 1'b0;
         pmem_addr_q  <= '0;
         s2_valid_q   <= 1'b0;
         s2_hit_q     <= 1'b0;
         s2_addr_q    <= '0;
         s2_way_q     <= '0;
         s2_line_q    <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         pmem_read_q <= (state_d == ST_FETCH);
         if (state_q == ST_IDLE) begin
            // A flush here takes effect before any refill the miss starts
            if (flush) begin
               for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
            end
            if (s2_valid_q && s2_hit_q) plru_q[s2_idx] <= plru_touch(plru_q[s2_idx], hit_way);
            if (s2_miss) begin
               pmem_addr_q <= {s2_addr_q[31:S_OFFSET], S_OFFSET'(0)};
            end else begin
               s2_valid_q <= s1_accept;
               s2_hit_q   <= |s1_way;
               s2_addr_q  <= mem_address;
               s2_way_q   <= s1_way;
               s2_line_q  <= s1_line;
            end
         end else begin
            if (flush) flush_pend_q <= 1'b1;
            if (fill) begin
               tag_q[s2_idx][victim]  <= s2_addr_q[31 -: S_TAG];
               data_q[s2_idx][victim] <= pmem_rdata;
               // A flush seen during the refill leaves even the new line invalid
               if (flush || flush_pend_q) begin
                  for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
               end else begin
                  valid_q[s2_idx][victim] <= 1'b1;
               end
               plru_q[s2_idx] <= plru_touch(plru_q[s2_idx], victim);
               flush_pend_q   <= 1'b0;
               s2_hit_q       <= 1'b1;
               s2_line_q      <= pmem_rdata;
               s2_way_q       <= NUM_WAYS'(1) << victim;
            end
         end
      end
   end

endmodule

// File: tb/tb_p_i_cache_nway.sv
// tb/tb_p_i_cache_nway.sv - directed self-checking bench for p_i_cache_nway
module tb_p_i_cache_nway;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, mem_read, flush, pmem_resp, sel;
   logic [31:0]  mem_address;
   logic         resp_a, pread_a, resp_b, pread_b;
   logic [31:0]  rdata_a, paddr_a, rdata_b, paddr_b;
   logic [255:0] prdata_a;
   logic [127:0] prdata_b;
   logic         o_resp, o_pread;
   logic [31:0]  o_rdata, o_paddr;
   int           n_chk = 0;
   int           n_fail = 0;

   typedef struct {
      logic        rst, rd, fl, presp;
      logic [31:0] addr;
      logic [2:0]  ck;      // [0] resp+pread, [1] rdata, [2] pmem_address
      logic        e_resp, e_pread;
      logic [31:0] e_data, e_paddr;
   } vec_t;
   vec_t tbl[$];

   p_i_cache_nway dut_a (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_address(mem_address), .flush(flush),
      .mem_resp(resp_a), .mem_rdata(rdata_a), .pmem_read(pread_a), .pmem_address(paddr_a),
      .pmem_rdata(prdata_a), .pmem_resp(pmem_resp)
   );

   p_i_cache_nway #(.S_OFFSET(4), .S_INDEX(4), .NUM_WAYS(2)) dut_b (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_address(mem_address), .flush(flush),
      .mem_resp(resp_b), .mem_rdata(rdata_b), .pmem_read(pread_b), .pmem_address(paddr_b),
      .pmem_rdata(prdata_b), .pmem_resp(pmem_resp)
   );

   // Backing-memory word contents as a function of byte address
   function automatic logic [31:0] wf(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   always_comb begin
      for (int k = 0; k < 8; k++) prdata_a[32*k +: 32] = wf(paddr_a + 32'(4*k));
      for (int k = 0; k < 4; k++) prdata_b[32*k +: 32] = wf(paddr_b + 32'(4*k));
      o_resp  = sel ? resp_b  : resp_a;
      o_pread = sel ? pread_b : pread_a;
      o_rdata = sel ? rdata_b : rdata_a;
      o_paddr = sel ? paddr_b : paddr_a;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic rd, input logic fl, input logic pr,
                      input logic [31:0] a, input logic [2:0] ck, input logic er,
                      input logic ep, input logic [31:0] ed, input logic [31:0] epa);
      vec_t v;
      v.rst = r; v.rd = rd; v.fl = fl; v.presp = pr; v.addr = a; v.ck = ck;
      v.e_resp = er; v.e_pread = ep; v.e_data = ed; v.e_paddr = epa;
      tbl.push_back(v);
   endtask

   // Cycle table: reset, cold miss + back-to-back hits, flush in IDLE, stray pmem_resp
   task automatic run_table(input logic [31:0] b, input string tag);
      tbl.delete();
      add(1,0,0,0, 0,     0, 0,0, 0,        0);
      add(0,1,0,0, b,     7, 0,0, 0,        0);
      add(0,1,0,0, b+4,   5, 0,0, 0,        0);
      add(0,1,0,0, b+4,   5, 0,1, 0,        b);
      add(0,1,0,0, b+4,   5, 0,1, 0,        b);
      add(0,1,0,1, b+4,   5, 0,1, 0,        b);
      add(0,1,0,0, b+4,   3, 1,0, wf(b),    0);
      add(0,1,0,0, b+8,   3, 1,0, wf(b+4),  0);
      add(0,0,0,0, 0,     3, 1,0, wf(b+8),  0);
      add(0,0,0,0, 0,     1, 0,0, 0,        0);
      add(0,1,0,0, b,     1, 0,0, 0,        0);
      add(0,1,1,0, b,     3, 1,0, wf(b),    0);
      add(0,1,0,0, b,     1, 0,0, 0,        0);
      add(0,0,0,0, 0,     1, 0,0, 0,        0);
      add(0,0,0,0, 0,     5, 0,1, 0,        b);
      add(0,0,0,1, 0,     1, 0,1, 0,        0);
      add(0,0,0,0, 0,     3, 1,0, wf(b),    0);
      add(0,0,0,1, 0,     1, 0,0, 0,        0);
      add(0,0,0,0, 0,     1, 0,0, 0,        0);
      add(0,1,0,0, b+4,   1, 0,0, 0,        0);
      add(0,0,0,0, 0,     3, 1,0, wf(b+4),  0);
      add(0,0,0,0, 0,     1, 0,0, 0,        0);
      for (int i = 0; i < tbl.size(); i++) begin
         step();
         rst = tbl[i].rst; mem_read = tbl[i].rd; mem_address = tbl[i].addr;
         flush = tbl[i].fl; pmem_resp = tbl[i].presp;
         @(negedge clk);
         if (tbl[i].ck[0]) begin
            chk1($sformatf("%s.row%0d.mem_resp", tag, i), o_resp, tbl[i].e_resp);
            chk1($sformatf("%s.row%0d.pmem_read", tag, i), o_pread, tbl[i].e_pread);
         end
         if (tbl[i].ck[1]) chk32($sformatf("%s.row%0d.mem_rdata", tag, i), o_rdata, tbl[i].e_data);
         if (tbl[i].ck[2]) chk32($sformatf("%s.row%0d.pmem_address", tag, i), o_paddr, tbl[i].e_paddr);
      end
      rst = 0; mem_read = 0; flush = 0; pmem_resp = 0;
   endtask

   task automatic do_reset();
      step(); rst = 1;
      step(); rst = 0;
   endtask

   // Single isolated fetch; a miss is refilled with pmem_resp two cycles after pmem_read rises
   task automatic read_one(input logic [31:0] a, input logic miss, input string nm);
      logic [31:0] la;
      la = sel ? (a & ~32'hF) : (a & ~32'h1F);
      step(); mem_read = 1; mem_address = a;
      step(); mem_read = 0;
      if (!miss) begin
         chk1({nm, ".hit_resp"}, o_resp, 1'b1);
         chk32({nm, ".hit_data"}, o_rdata, wf(a));
      end else begin
         chk1({nm, ".miss_resp"}, o_resp, 1'b0);
         step();
         chk1({nm, ".pmem_read"}, o_pread, 1'b1);
         chk32({nm, ".pmem_address"}, o_paddr, la);
         step();
         step(); pmem_resp = 1;
         step(); pmem_resp = 0;
         chk1({nm, ".fill_resp"}, o_resp, 1'b1);
         chk32({nm, ".fill_data"}, o_rdata, wf(a));
         chk1({nm, ".pmem_read_drop"}, o_pread, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1; mem_read = 0; mem_address = 0; flush = 0; pmem_resp = 0; sel = 0;

      run_table(32'h40, "a");

      // Four tags in set 2 fill ways 0..3; after touching A and C the victim is B
      do_reset();
      read_one(32'h140, 1, "a.lru.A0");
      read_one(32'h240, 1, "a.lru.B0");
      read_one(32'h340, 1, "a.lru.C0");
      read_one(32'h440, 1, "a.lru.D0");
      read_one(32'h144, 0, "a.lru.A1");
      read_one(32'h348, 0, "a.lru.C1");
      read_one(32'h540, 1, "a.lru.E0");
      read_one(32'h240, 1, "a.lru.B1");
      read_one(32'h140, 0, "a.lru.A2");
      read_one(32'h34C, 0, "a.lru.C2");
      read_one(32'h544, 0, "a.lru.E1");
      read_one(32'h440, 1, "a.lru.D1");

      // Flush while the refill is outstanding
      step(); mem_read = 1; mem_address = 32'h608;
      step(); mem_read = 0;
      chk1("a.ffetch.miss_resp", o_resp, 1'b0);
      step(); chk1("a.ffetch.pmem_read", o_pread, 1'b1); flush = 1;
      step(); flush = 0;
      step(); pmem_resp = 1;
      step(); pmem_resp = 0;
      chk1("a.ffetch.resp", o_resp, 1'b1);
      chk32("a.ffetch.data", o_rdata, wf(32'h608));
      read_one(32'h140, 1, "a.ffetch.old_line");
      read_one(32'h608, 1, "a.ffetch.same_line");
      read_one(32'h60C, 0, "a.ffetch.refilled");

      // Reset in the middle of a refill
      step(); mem_read = 1; mem_address = 32'h700;
      step(); mem_read = 0;
      step(); chk1("a.rst.pmem_read_before", o_pread, 1'b1); rst = 1;
      step(); rst = 0;
      chk1("a.rst.pmem_read_after", o_pread, 1'b0);
      chk1("a.rst.resp_after", o_resp, 1'b0);
      chk32("a.rst.pmem_address", o_paddr, 32'h0);
      step(); pmem_resp = 1;
      chk1("a.rst.resp_late", o_resp, 1'b0);
      step(); pmem_resp = 0;
      chk1("a.rst.resp_ignored", o_resp, 1'b0);
      chk1("a.rst.pmem_read_idle", o_pread, 1'b0);
      read_one(32'h700, 1, "a.rst.reread");

      // Two-way, 16-byte-line, 16-set configuration
      sel = 1;
      run_table(32'h20, "b");
      do_reset();
      read_one(32'h120, 1, "b.lru.A0");
      read_one(32'h220, 1, "b.lru.B0");
      read_one(32'h124, 0, "b.lru.A1");
      read_one(32'h520, 1, "b.lru.E0");
      read_one(32'h228, 1, "b.lru.B1");
      read_one(32'h52C, 0, "b.lru.E1");
      read_one(32'h120, 1, "b.lru.A2");

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/p_i_cache_nway.md
# p_i_cache_nway

Parametrised two-stage pipelined, read-only instruction cache: configurable set count, way count and line size, tree pseudo-LRU replacement, and a whole-cache `flush` for `fence.i`. It sits between the fetch stage and the instruction-side arbiter port. It returns one 32-bit word per cycle on back-to-back hits and stalls the pipeline for the duration of a line refill.

## Interface
- `S_OFFSET`, 5: log2 bytes per line; line width `S_LINE = 8*2**S_OFFSET` bits; minimum 2.
- `S_INDEX`, 3: log2 number of sets; `S_TAG = 32 - S_OFFSET - S_INDEX`.
- `NUM_WAYS`, 4: associativity; a power of two, at least 2; PLRU state is `NUM_WAYS-1` bits per set.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_read` in 1: fetch request valid.
- `mem_address` in 32: fetch byte address; bits [1:0] ignored.
- `flush` in 1: one-cycle pulse requesting invalidation of every line.
- `mem_resp` out 1: `mem_rdata` is valid for the request held in stage 2.
- `mem_rdata` out 32: the requested instruction word.
- `pmem_read` out 1: line-refill request.
- `pmem_address` out 32: line-aligned refill address `{tag, index, S_OFFSET'b0}`.
- `pmem_rdata` in S_LINE: refill line data; valid when `pmem_resp` is high.
- `pmem_resp` in 1: refill complete (one cycle).

## Operation
- Storage is flop-based: valid, tag and data per way per set, plus tree-PLRU bits per set.
- **Stage 1 (lookup):**
  - A request is accepted when `mem_read` is high and the stage is not stalled.
  - Index, tag compare and way select are combinational on `mem_address`.
  - The result (address, hit, way one-hot, line) is registered into the stage-2 register with valid=1.
  - A cycle with no accepted request loads valid=0.
- **Stage 2 (deliver):**
  - On valid & hit: `mem_resp`=1, `mem_rdata` = word selected by address bits [S_OFFSET-1:2]. The PLRU for that set is updated to point away from the hit way.
  - On valid & miss: miss is detected, `mem_resp`=0, and the FSM leaves IDLE.
- **FSM states:**
  - IDLE: normal pipelined operation. Goes to FETCH on a stage-2 miss.
  - FETCH:
    - `pmem_read`=1 and `pmem_address` is held.
    - Stage 1 and stage 2 are frozen.
    - On `pmem_resp`:
      - Victim way = lowest-index invalid way, otherwise the PLRU victim.
      - Write line and tag; set valid; update PLRU toward the filled way.
      - Capture the line into stage 2 as a hit; go to IDLE.
- **Requester rule:** while `mem_resp` is low for an outstanding request, the requester holds `mem_read` and `mem_address` of its next request stable.
- **Flush:**
  - In IDLE, all valid bits clear at the edge. Stage 1 does not accept in the flush cycle, so the next lookup sees the invalidated arrays. A stage-2 hit in that same cycle is still delivered.
  - During FETCH, the flush is latched as pending. On the fill cycle, all valid bits clear and the filled line is written with valid=0. The refill word is still returned to the missed request.
- **Victim selection:** the PLRU tree is walked from the root. Each node bit=0 selects the lower half. On access, each node on the path is set to point at the opposite half.

## Timing
- Hit latency is 1 cycle: request accepted at edge N, `mem_resp` high in cycle N+1. Back-to-back hits give one word per cycle.
- Miss:
  - Cycle M: stage 2 misses; `mem_resp`=0 and stage 1 stalls.
  - Cycles M+1 through R: `pmem_read`=1 (registered), where R is the `pmem_resp` cycle.
  - Cycle R+1: `mem_resp`=1 with the refill word. Stage 1 accepts the held request, which sees the new line.
  - Total miss penalty: (R−M)+1 cycles beyond a hit.
- `pmem_read` drops in cycle R+1. A `pmem_resp` arriving in IDLE is ignored.
- **Reset values:**
  - All valid and PLRU bits 0; stage-2 valid 0; FSM IDLE; flush-pending 0.
  - `mem_resp`=0, `pmem_read`=0, `pmem_address`=0, `mem_rdata`=0.
- **Reset during FETCH:** the next cycle is IDLE with `pmem_read`=0 and no array write.
- **Simultaneous events:**
  - `flush` and a stage-2 miss in the same cycle: invalidation is applied first, then FETCH proceeds with flush-pending clear.
  - A hit to the same set while a PLRU update is in progress cannot occur, because updates occur only in stage 2 and stage 1 only reads.

## Test plan
- **Cold miss then hits:**
  - Read 0x0000_0040, then 0x44, 0x48.
  - Required: `pmem_address`=0x40. After `pmem_resp`, three consecutive cycles with `mem_resp`=1 and words 0,1,2 of the line.
- **Fill order and LRU eviction** (defaults, 4 ways):
  - Miss to tags A,B,C,D in set 2; they fill ways 0,1,2,3. Hit A, then hit C.
  - Required: a miss to E fills way 1 (B). A following read of B misses.
- **Flush in IDLE:**
  - Line resident and hitting; pulse `flush`; re-read the same address.
  - Required: `mem_resp` low, then `pmem_read`=1 for that line.
- **Flush during FETCH:**
  - Pulse `flush` with `pmem_read` high.
  - Required: the missed word is returned. A repeat read of the same address misses again.
- **Reset mid-refill:**
  - Assert `rst` for one cycle in FETCH, then drive `pmem_resp`.
  - Required: `pmem_read`=0 in the cycle after reset, no `mem_resp`, and a later read of that line misses.
- **Parameter sweep** (`NUM_WAYS`=2, `S_INDEX`=4, `S_OFFSET`=4):
  - Repeat the first two scenarios with 128-bit lines and addresses scaled to the 16-byte line.
  - Required: identical behaviour.
